// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//
// Read-side master for one port of a ram2p-style dual-port RAM. The block
// walks a range of RAM words and streams them out on a valid/ready interface.
// The RAM has a fixed 1-cycle registered read latency. A 2-entry output
// buffer absorbs that latency, so a downstream stall never drops a word.
//
// Parameters
//   AWID  RAM address width; the RAM depth is 2**AWID words.
//   DWID  RAM and stream data width.
//
// Ports
//   clk         single clock
//   rst         synchronous reset, active-high
//   i_start     start request; accepted only in IDLE (o_busy=0)
//   i_base      first RAM address, sampled on start
//   i_len       word count 0..2**AWID, sampled on start
//   o_busy      high from the cycle after start acceptance through the done cycle
//   o_done      1-cycle pulse when the transfer completes
//   o_ram_addr  RAM read address
//   o_ram_we    RAM write enable, tied to 0
//   i_ram_data  RAM read data, valid one clock after o_ram_addr
//   o_valid     stream data valid
//   i_ready     stream consumer ready
//   o_data      stream data
//   o_last      marks the final word of a transfer, qualified by o_valid
//   o_stall_cnt cycles with o_valid=1 and i_ready=0, saturating
//               (only present when RAM_STREAM_READER_STALL_CNT_EN is defined)
//
// Optional feature macro: RAM_STREAM_READER_STALL_CNT_EN

module ram_stream_reader #(
  parameter int AWID = 8,
  parameter int DWID = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [AWID-1:0] i_base,
  input  logic [AWID:0]   i_len,
  output logic            o_busy,
  output logic            o_done,
  output logic [AWID-1:0] o_ram_addr,
  output logic            o_ram_we,
  input  logic [DWID-1:0] i_ram_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [DWID-1:0] o_data,
  output logic            o_last
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]     o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [AWID-1:0] ADDR_STEP = 1;
  localparam logic [AWID:0]   ONE_WORD  = 1;
  localparam logic [AWID:0]   NO_WORDS  = 0;

  state_t state, state_next;

  logic [AWID-1:0] addr_q;
  logic [AWID:0]   remain_q;

  logic            in_flight_q;
  logic            in_flight_last_q;

  logic [1:0]      buf_cnt_q;
  logic [DWID-1:0] head_data_q;
  logic            head_last_q;
  logic [DWID-1:0] tail_data_q;
  logic            tail_last_q;

  logic            start_accept;
  logic            push;
  logic            pop;
  logic            issue;
  logic            last_issue;
  logic [2:0]      occupancy;
  logic [2:0]      issue_limit;

  // A start request is honoured only while idle; in RUN, DRAIN and FIN it is
  // simply dropped, so base and length are never resampled mid-transfer.
  assign start_accept = (state == IDLE) && i_start;

  // The stream side: the head of the buffer is what is presented, and a word
  // leaves on any edge where it is both valid and accepted. Valid comes only
  // from the occupancy register, never from i_ready.
  assign o_valid = (buf_cnt_q != 2'd0);
  assign o_data  = head_data_q;
  assign o_last  = o_valid && head_last_q;
  assign pop     = o_valid && i_ready;

  // A read issued last cycle returns its data this cycle, so that word is
  // pushed into the buffer on this edge.
  assign push = in_flight_q;

  // Issue throttling: words already buffered plus the one still coming back
  // from the RAM, minus the one leaving this cycle, must leave room for one
  // more. Written as "occ + in_flight < 2 + pop" to stay free of underflow.
  assign occupancy   = {1'b0, buf_cnt_q} + {2'b00, in_flight_q};
  assign issue_limit = 3'd2 + {2'b00, pop};
  assign issue       = (state == RUN) && (remain_q != NO_WORDS) && (occupancy < issue_limit);
  assign last_issue  = issue && (remain_q == ONE_WORD);

  assign o_ram_addr = addr_q;
  assign o_ram_we   = 1'b0;

  // State register. Reset returns the controller to IDLE, abandoning any
  // transfer in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero-length request skips straight to FIN so it
  // still produces exactly one done pulse. RUN leaves as soon as the final
  // address has gone out; DRAIN waits for the consumer to take the word
  // marked last.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_accept) begin
          if (i_len == NO_WORDS) begin
            state_next = FIN;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last_q) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state alone. Busy covers every non-idle
  // state, which includes the FIN cycle carrying the done pulse.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (state)
      IDLE:    o_busy = 1'b0;
      RUN:     o_busy = 1'b1;
      DRAIN:   o_busy = 1'b1;
      FIN: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: o_busy = 1'b0;
    endcase
  end

  // Address walker. The base is loaded on start acceptance and steps by one
  // on every issued read, wrapping silently at the top of the RAM. Between
  // issues the address just holds. The remaining-word counter is one bit
  // wider than the address so a full-RAM transfer can be expressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (start_accept) begin
      addr_q   <= i_base;
      remain_q <= i_len;
    end else if (issue) begin
      addr_q   <= addr_q + ADDR_STEP;
      remain_q <= remain_q - ONE_WORD;
    end
  end

  // Tracks the read currently travelling through the RAM's output register,
  // together with whether it is the final word of the transfer. Reset drops
  // it, so data already in flight never reaches the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      in_flight_q      <= issue;
      in_flight_last_q <= last_issue;
    end
  end

  // Two-entry output FIFO built from a head and a tail register. The head
  // feeds the stream outputs directly, so it only changes on a pop or when
  // a word lands in an empty buffer; that keeps data and last steady while
  // the consumer stalls. A simultaneous push and pop with one entry replaces
  // the head; with two entries the tail moves up and the new word takes its
  // place. The issue throttle guarantees a push never arrives when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt_q   <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt_q == 2'd0) begin
            head_data_q <= i_ram_data;
            head_last_q <= in_flight_last_q;
          end else begin
            tail_data_q <= i_ram_data;
            tail_last_q <= in_flight_last_q;
          end
          buf_cnt_q <= buf_cnt_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          buf_cnt_q   <= buf_cnt_q - 2'd1;
        end
        2'b11: begin
          if (buf_cnt_q == 2'd1) begin
            head_data_q <= i_ram_data;
            head_last_q <= in_flight_last_q;
          end else begin
            head_data_q <= tail_data_q;
            head_last_q <= tail_last_q;
            tail_data_q <= i_ram_data;
            tail_last_q <= in_flight_last_q;
          end
        end
        default: begin
          buf_cnt_q <= buf_cnt_q;
        end
      endcase
    end
  end

`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Back-pressure counter: one count per cycle the consumer leaves a valid
  // word waiting. It saturates instead of wrapping, restarts with each new
  // transfer, and keeps its final value after done so it can be read later.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (start_accept) begin
      stall_cnt_q <= 16'h0000;
    end else if (o_valid && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//
// Self-checking bench for ram_stream_reader. A behavioural dual-port RAM
// preloaded with RAM[i] = 16'h1000 + i answers the read port. For every
// transfer, the expected word list is built from the address rule
// (base + k) mod 256. Each accepted word is checked against that list, in
// order. Also checked: latency, done/busy timing, hold during stalls, reset
// abort, ignored starts and, when RAM_STREAM_READER_STALL_CNT_EN is
// defined, the stall counter.

module tb_ram_stream_reader;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_base;
  logic [8:0]  i_len;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_ram_addr;
  logic        o_ram_we;
  logic [15:0] i_ram_data;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_last;
`ifdef RAM_STREAM_READER_STALL_CNT_EN
  logic [15:0] o_stall_cnt;
`endif

  logic [15:0] mem [256];

  int testsRun;
  int testsFailed;

  ram_stream_reader #(
    .AWID(8),
    .DWID(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_base     (i_base),
    .i_len      (i_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_ram_addr (o_ram_addr),
    .o_ram_we   (o_ram_we),
    .i_ram_data (i_ram_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_last     (o_last)
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preload the RAM with its own address plus 16'h1000.
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h1000 + 16'(i);
    end
  end

  // Behavioural read port with a one-clock registered latency.
  always @(posedge clk) begin
    i_ram_data <= mem[o_ram_addr];
  end

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", tag, actual, expected);
    end
  endtask

  // Checks that all outputs sit at their reset values.
  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_done"}, o_done, 0);
    checkOutput({tag, "_valid"}, o_valid, 0);
    checkOutput({tag, "_last"}, o_last, 0);
    checkOutput({tag, "_data"}, o_data, 0);
    checkOutput({tag, "_addr"}, o_ram_addr, 0);
    checkOutput({tag, "_we"}, o_ram_we, 0);
`ifdef RAM_STREAM_READER_STALL_CNT_EN
    checkOutput({tag, "_stallcnt"}, o_stall_cnt, 0);
`endif
  endtask

  // Runs one transfer from base/len and scores the stream against the
  // address-rule model. randomReady toggles i_ready with 50% probability.
  // abortAfter > 0 resets the DUT once that many words have been accepted.
  // interfere pulses i_start with other parameters while busy, and again
  // in the FIN cycle.
  task automatic applyStimulus(input logic [7:0] base, input logic [8:0] len,
                               input bit randomReady, input int abortAfter,
                               input bit interfere);
    logic [15:0] expData[$];
    int          budget;
    int          firstValid;
    int          lastAccept;
    int          doneCyc;
    int          stalls;
    int          accepted;
    bit          doneSeen;
    bit          prevStall;
    logic [15:0] heldData;
    logic        heldLast;

    for (int k = 0; k < int'(len); k++) begin
      expData.push_back(16'(32'h1000 + ((int'(base) + k) % 256)));
    end
    budget     = 4 * int'(len) + 40;
    firstValid = -1;
    lastAccept = -1;
    doneCyc    = -1;
    stalls     = 0;
    accepted   = 0;
    doneSeen   = 0;
    prevStall  = 0;
    heldData   = '0;
    heldLast   = 1'b0;

    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_base  = base;
    i_len   = len;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;

    for (int cyc = 0; cyc < budget && !doneSeen; cyc++) begin
      i_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start = interfere && (cyc == 3 || (!randomReady && cyc == int'(len) + 2));
      if (interfere) begin
        i_base = base + 8'h55;
        i_len  = len + 9'd3;
      end
      @(negedge clk);
      checkOutput("busy", o_busy, 1);
      checkOutput("ramWe", o_ram_we, 0);
      if (prevStall) begin
        checkOutput("holdValid", o_valid, 1);
        checkOutput("holdData", o_data, heldData);
        checkOutput("holdLast", o_last, heldLast);
      end
      if (o_valid && firstValid < 0) firstValid = cyc;
      if (o_valid && i_ready) begin
        checkOutput("wordExpected", expData.size() != 0, 1);
        if (expData.size() != 0) begin
          checkOutput("data", o_data, expData[0]);
          checkOutput("last", o_last, expData.size() == 1);
          void'(expData.pop_front());
        end
        accepted++;
        lastAccept = cyc;
      end
      prevStall = o_valid && !i_ready;
      if (prevStall) begin
        heldData = o_data;
        heldLast = o_last;
        stalls++;
      end
      if (o_done) begin
        doneSeen = 1;
        doneCyc  = cyc;
      end
      if (abortAfter > 0 && accepted == abortAfter) break;
      @(posedge clk);
      #1;
    end

    if (abortAfter > 0) begin
      checkOutput("abortReached", accepted, abortAfter);
      checkOutput("abortNoDone", doneSeen, 0);
      @(posedge clk);
      #1;
      i_start = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkIdleZero("abort");
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        checkOutput("abortQuietValid", o_valid, 0);
        checkOutput("abortQuietDone", o_done, 0);
      end
    end else begin
      i_start = 1'b0;
      i_ready = 1'b1;
      checkOutput("doneSeen", doneSeen, 1);
      checkOutput("wordCount", accepted, len);
      checkOutput("wordsLeft", expData.size(), 0);
      if (!randomReady) begin
        checkOutput("doneCyc", doneCyc, int'(len) + ((len != 0) ? 2 : 0));
        if (len != 0) begin
          checkOutput("firstValidCyc", firstValid, 2);
          checkOutput("lastAcceptCyc", lastAccept, int'(len) + 1);
        end else begin
          checkOutput("noValid", firstValid, -1);
        end
      end
      @(negedge clk);
      checkOutput("afterDone", o_done, 0);
      checkOutput("afterBusy", o_busy, 0);
      checkOutput("afterValid", o_valid, 0);
`ifdef RAM_STREAM_READER_STALL_CNT_EN
      checkOutput("stallCnt", o_stall_cnt, stalls);
`endif
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base      = '0;
    i_len       = '0;
    i_ready     = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus(8'h10, 9'd4, 1'b0, 0, 1'b0);

    applyStimulus(8'h14, 9'd0, 1'b0, 0, 1'b0);
    checkOutput("zeroLenAddr", o_ram_addr, 8'h14);
    repeat (3) @(negedge clk);
    checkOutput("zeroLenAddrHeld", o_ram_addr, 8'h14);

    applyStimulus(8'hFE, 9'd4, 1'b0, 0, 1'b0);

    applyStimulus(8'h20, 9'd16, 1'b1, 0, 1'b0);

    applyStimulus(8'h30, 9'd10, 1'b0, 3, 1'b0);
    applyStimulus(8'h00, 9'd2, 1'b0, 0, 1'b0);

    applyStimulus(8'h40, 9'd6, 1'b0, 0, 1'b1);

    applyStimulus(8'h00, 9'd256, 1'b0, 0, 1'b0);

    for (int t = 0; t < 5; t++) begin
      applyStimulus(8'($urandom_range(0, 255)), 9'($urandom_range(1, 40)), 1'b1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
